// File: rtl/alu_request_arbiter_pkg.sv
// Shared types and constants for the ALU request arbiter and the ALU it shares.
package alu_request_arbiter_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FUNC_WIDTH = 4;

    localparam logic [FUNC_WIDTH-1:0] FUNC_ADD = 4'd0;
    localparam logic [FUNC_WIDTH-1:0] FUNC_SUB = 4'd1;
    localparam logic [FUNC_WIDTH-1:0] FUNC_AND = 4'd2;
    localparam logic [FUNC_WIDTH-1:0] FUNC_OR  = 4'd3;
    localparam logic [FUNC_WIDTH-1:0] FUNC_XOR = 4'd4;
    localparam logic [FUNC_WIDTH-1:0] FUNC_LSS = 4'd5;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arbState_t;

    // Two's-complement add overflow from the operand and sum sign bits.
    function automatic logic signed_add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/arithmeticLogicUnit.sv
// Combinational ALU: add/sub with signed overflow, bitwise ops and signed less-than.
module arithmeticLogicUnit
    import alu_request_arbiter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [FUNC_WIDTH-1:0] i_func,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_overflow,
    output logic                  o_compare
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  w_lt;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_lt   = $signed(i_a) < $signed(i_b);

    // Function decode; unknown codes produce an all-zero response.
    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        o_compare  = 1'b0;
        case (i_func)
            FUNC_ADD: begin
                o_result   = w_sum;
                o_overflow = signed_add_ovf(i_a[MSB], i_b[MSB], w_sum[MSB]);
            end
            FUNC_SUB: begin
                o_result   = w_diff;
                o_overflow = signed_add_ovf(i_a[MSB], ~i_b[MSB], w_diff[MSB]);
            end
            FUNC_AND: o_result = i_a & i_b;
            FUNC_OR:  o_result = i_a | i_b;
            FUNC_XOR: o_result = i_a ^ i_b;
            FUNC_LSS: begin
                o_result  = {{(DATA_WIDTH-1){1'b0}}, w_lt};
                o_compare = w_lt;
            end
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/rr_picker.sv
// Round-robin search: first set request bit after i_last, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 2,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic               o_found,
    output logic [ID_W-1:0]    o_idx
);

    logic [ID_W-1:0] w_cand;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand  = ID_W'((int'(i_last) + k) % NUM_REQ);
            o_found = o_found | i_req[w_cand];
            o_idx   = i_req[w_cand] ? w_cand : o_idx;
        end
    end

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin grant, one op in flight,
// registered response and per-requester sticky overflow.
module alu_request_arbiter
    import alu_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                          _clock,
    input  logic                          _reset,
    input  logic [NUM_REQ-1:0]            _reqValid,
    output logic [NUM_REQ-1:0]            reqReady,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] _reqValA,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] _reqValB,
    input  logic [NUM_REQ*FUNC_WIDTH-1:0] _reqFunc,
    output logic [NUM_REQ-1:0]            respValid,
    input  logic [NUM_REQ-1:0]            _respReady,
    output logic [DATA_WIDTH-1:0]         respResult,
    output logic                          respOverflow,
    output logic                          respCompare,
    output logic [NUM_REQ-1:0]            stickyOverflow,
    input  logic [NUM_REQ-1:0]            _ovfClear,
    output logic                          busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0  = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]    LAST_RESET = ID_W'(NUM_REQ - 1);

    arbState_t             r_state;
    arbState_t             w_next_state;
    logic [ID_W-1:0]       r_last_grant;
    logic [ID_W-1:0]       r_owner;
    logic [DATA_WIDTH-1:0] r_op_a;
    logic [DATA_WIDTH-1:0] r_op_b;
    logic [FUNC_WIDTH-1:0] r_func;
    logic [NUM_REQ-1:0]    r_resp_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_overflow;
    logic                  r_compare;
    logic [NUM_REQ-1:0]    r_sticky;
    logic                  r_busy;

    logic                  w_found;
    logic [ID_W-1:0]       w_win;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_alu_ovf;
    logic                  w_alu_cmp;
    logic [NUM_REQ-1:0]    w_sticky_set;
    logic                  w_accept;
    logic                  w_consume;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req   (_reqValid),
        .i_last  (r_last_grant),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    arithmeticLogicUnit u_alu (
        .i_a        (r_op_a),
        .i_b        (r_op_b),
        .i_func     (r_func),
        .o_result   (w_alu_result),
        .o_overflow (w_alu_ovf),
        .o_compare  (w_alu_cmp)
    );

    assign w_accept     = (r_state == ARB_IDLE) && w_found;
    assign w_consume    = (r_state == ARB_RESP) && _respReady[r_owner];
    assign reqReady     = w_accept ? (ONE_HOT_0 << w_win) : '0;
    assign w_sticky_set = ((r_state == ARB_EXEC) && w_alu_ovf) ? (ONE_HOT_0 << r_owner) : '0;

    assign respValid      = r_resp_valid;
    assign respResult     = r_result;
    assign respOverflow   = r_overflow;
    assign respCompare    = r_compare;
    assign stickyOverflow = r_sticky;
    assign busy           = r_busy;

    // Sequencer next state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) w_next_state = ARB_EXEC;
                else         w_next_state = ARB_IDLE;
            end
            ARB_EXEC: w_next_state = ARB_RESP;
            ARB_RESP: begin
                if (w_consume) w_next_state = ARB_IDLE;
                else           w_next_state = ARB_RESP;
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // State, operand latch and response registers.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            r_state      <= ARB_IDLE;
            r_busy       <= 1'b0;
            r_last_grant <= LAST_RESET;
            r_owner      <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_func       <= '0;
            r_resp_valid <= '0;
            r_result     <= '0;
            r_overflow   <= 1'b0;
            r_compare    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != ARB_IDLE);
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_op_a  <= _reqValA[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                        r_op_b  <= _reqValB[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                        r_func  <= _reqFunc[int'(w_win)*FUNC_WIDTH +: FUNC_WIDTH];
                    end
                end
                ARB_EXEC: begin
                    r_result     <= w_alu_result;
                    r_overflow   <= w_alu_ovf;
                    r_compare    <= w_alu_cmp;
                    r_resp_valid <= ONE_HOT_0 << r_owner;
                end
                ARB_RESP: begin
                    if (w_consume) begin
                        r_resp_valid <= '0;
                        r_last_grant <= r_owner;
                    end
                end
                default: r_resp_valid <= '0;
            endcase
        end
    end

    // Sticky overflow: a set on the same edge as a clear wins.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (r_sticky & ~_ovfClear) | w_sticky_set;
        end
    end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Self-checking bench: directed steps plus randomized ops against a behavioural model.
module tb_alu_request_arbiter;
    import alu_request_arbiter_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int FW = FUNC_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      valid2 = '0, rdy2, rv2, rr2 = '0, sticky2, clr2 = '0;
    logic [2*DW-1:0] va2 = '0, vb2 = '0;
    logic [2*FW-1:0] fn2 = '0;
    logic [DW-1:0]   res2;
    logic            ovf2, cmp2, busy2;

    logic [2:0]      valid3 = '0, rdy3, rv3, rr3 = '0, sticky3, clr3 = '0;
    logic [3*DW-1:0] va3 = '0, vb3 = '0;
    logic [3*FW-1:0] fn3 = '0;
    logic [DW-1:0]   res3;
    logic            ovf3, cmp3, busy3;

    alu_request_arbiter #(.NUM_REQ(2)) dut2 (
        ._clock(clk), ._reset(rst), ._reqValid(valid2), .reqReady(rdy2),
        ._reqValA(va2), ._reqValB(vb2), ._reqFunc(fn2), .respValid(rv2),
        ._respReady(rr2), .respResult(res2), .respOverflow(ovf2), .respCompare(cmp2),
        .stickyOverflow(sticky2), ._ovfClear(clr2), .busy(busy2)
    );

    alu_request_arbiter #(.NUM_REQ(3)) dut3 (
        ._clock(clk), ._reset(rst), ._reqValid(valid3), .reqReady(rdy3),
        ._reqValA(va3), ._reqValB(vb3), ._reqFunc(fn3), .respValid(rv3),
        ._respReady(rr3), .respResult(res3), .respOverflow(ovf3), .respCompare(cmp3),
        .stickyOverflow(sticky3), ._ovfClear(clr3), .busy(busy3)
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] a2 [2];
    logic [DW-1:0] b2 [2];
    logic [FW-1:0] f2 [2];
    int            last2 = 1;
    logic [1:0]    sticky_m = 2'b00;
    int            last3 = 2;
    int            n3 = 0;
    int            cyc3 = 0;
    int            w3 = 0;
    logic [FW-1:0] ftab [7] = '{FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_LSS, 4'hF};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int last, input logic [7:0] mask, input int n);
        for (int k = 1; k <= n; k++) begin
            if (mask[(last + k) % n]) return (last + k) % n;
        end
        return -1;
    endfunction

    function automatic void ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [FW-1:0] f, output logic [DW-1:0] r,
                                    output logic o, output logic c);
        longint sa, sb, s, lim;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = longint'(1) <<< (DW - 1);
        r = '0; o = 1'b0; c = 1'b0; s = 0;
        case (f)
            FUNC_ADD: begin s = sa + sb; r = DW'(s); o = (s >= lim) || (s < -lim); end
            FUNC_SUB: begin s = sa - sb; r = DW'(s); o = (s >= lim) || (s < -lim); end
            FUNC_AND: r = a & b;
            FUNC_OR:  r = a | b;
            FUNC_XOR: r = a ^ b;
            FUNC_LSS: begin c = (sa < sb); r = c ? DW'(1) : DW'(0); end
            default:  r = '0;
        endcase
    endfunction

    task automatic op2(input logic [1:0] mask, input int wait_cyc, input logic [1:0] clr_exec);
        int w;
        logic [DW-1:0] er;
        logic eo, ec;
        logic [1:0] oh;
        va2 = {a2[1], a2[0]};
        vb2 = {b2[1], b2[0]};
        fn2 = {f2[1], f2[0]};
        valid2 = mask;
        #1;
        w  = pick(last2, 8'(mask), 2);
        oh = 2'b01 << w;
        chk("grant", 64'(rdy2), 64'(oh));
        chk("busy_idle", 64'(busy2), 64'(1'b0));
        ref_alu(a2[w], b2[w], f2[w], er, eo, ec);
        @(posedge clk); #1;
        clr2 = clr_exec;
        #1;
        chk("no_grant_exec", 64'(rdy2), 64'(2'b00));
        chk("busy_exec", 64'(busy2), 64'(1'b1));
        chk("rv_exec", 64'(rv2), 64'(2'b00));
        @(posedge clk); #1;
        sticky_m = (sticky_m & ~clr_exec) | (eo ? oh : 2'b00);
        clr2 = 2'b00;
        chk("rv_resp", 64'(rv2), 64'(oh));
        chk("result", 64'(res2), 64'(er));
        chk("overflow", 64'(ovf2), 64'(eo));
        chk("compare", 64'(cmp2), 64'(ec));
        chk("sticky", 64'(sticky2), 64'(sticky_m));
        for (int i = 0; i < wait_cyc; i++) begin
            valid2 = 2'b11;
            rr2 = ~oh;
            @(posedge clk); #1;
            chk("rv_hold", 64'(rv2), 64'(oh));
            chk("res_hold", 64'(res2), 64'(er));
            chk("busy_hold", 64'(busy2), 64'(1'b1));
            chk("no_grant_resp", 64'(rdy2), 64'(2'b00));
        end
        rr2 = oh;
        @(posedge clk); #1;
        rr2 = 2'b00;
        valid2 = 2'b00;
        last2 = w;
        chk("rv_done", 64'(rv2), 64'(2'b00));
        chk("busy_done", 64'(busy2), 64'(1'b0));
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_rv", 64'(rv2), 64'(2'b00));
        chk("rst_busy", 64'(busy2), 64'(1'b0));
        chk("rst_res", 64'(res2), 64'(0));
        chk("rst_ovf", 64'(ovf2), 64'(1'b0));
        chk("rst_cmp", 64'(cmp2), 64'(1'b0));
        chk("rst_sticky", 64'(sticky2), 64'(2'b00));
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: req0 ADD 5,3
        a2[0] = 16'd5; b2[0] = 16'd3; f2[0] = FUNC_ADD;
        a2[1] = 16'd0; b2[1] = 16'd0; f2[1] = FUNC_ADD;
        op2(2'b01, 0, 2'b00);
        chk("t1_result_lit", 64'(res2), 64'(16'd8));

        // 2: response held off for 3 cycles while req1 waits
        op2(2'b01, 3, 2'b00);

        // 3: continuous requests alternate
        a2[0] = 16'd10; b2[0] = 16'd4; f2[0] = FUNC_SUB;
        a2[1] = 16'h00F0; b2[1] = 16'h0F0F; f2[1] = FUNC_XOR;
        for (int i = 0; i < 4; i++) op2(2'b11, 0, 2'b00);

        // 3b: three requesters wrap 0,1,2,0
        valid3 = 3'b111;
        rr3 = 3'b111;
        while (n3 < 4 && cyc3 < 40) begin
            #1;
            if (rdy3 != 3'b000) begin
                w3 = pick(last3, 8'h07, 3);
                chk("wrap_grant", 64'(rdy3), 64'(3'b001 << w3));
                last3 = w3;
                n3++;
            end
            @(posedge clk); #1;
            cyc3++;
        end
        chk("wrap_count", 64'(n3), 64'(4));
        valid3 = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        rr3 = 3'b000;

        // 4: overflow on req1, sticky persistence, clear, set-wins
        a2[1] = 16'h7FFF; b2[1] = 16'h0001; f2[1] = FUNC_ADD;
        op2(2'b10, 0, 2'b00);
        chk("t4_sticky_lit", 64'(sticky2), 64'(2'b10));
        @(posedge clk); #1;
        chk("t4_persist", 64'(sticky2), 64'(sticky_m));
        clr2 = 2'b10;
        @(posedge clk); #1;
        clr2 = 2'b00;
        sticky_m = sticky_m & ~2'b10;
        chk("t4_cleared", 64'(sticky2), 64'(sticky_m));
        op2(2'b10, 0, 2'b10);
        chk("t4_set_wins", 64'(sticky2), 64'(2'b10));

        // 5: LSS, SUB zero, illegal func
        a2[0] = 16'hFFFF; b2[0] = 16'h0000; f2[0] = FUNC_LSS;
        op2(2'b01, 0, 2'b00);
        a2[0] = 16'h0000; b2[0] = 16'h0000; f2[0] = FUNC_SUB;
        op2(2'b01, 1, 2'b00);
        a2[0] = 16'h1234; b2[0] = 16'h4321; f2[0] = 4'hF;
        op2(2'b01, 0, 2'b00);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 2; r++) begin
                a2[r] = ($urandom_range(0, 3) == 0) ? 16'h7FFF : DW'($urandom);
                b2[r] = DW'($urandom);
                f2[r] = ftab[$urandom_range(0, 6)];
            end
            op2(2'($urandom_range(1, 3)), $urandom_range(0, 2), 2'($urandom_range(0, 3)));
        end

        // 6: reset during EXEC, with non-zero prior state
        a2[0] = 16'h7FFF; b2[0] = 16'h0001; f2[0] = FUNC_ADD;
        op2(2'b01, 0, 2'b00);
        va2 = {a2[1], a2[0]};
        vb2 = {b2[1], b2[0]};
        fn2 = {f2[1], f2[0]};
        valid2 = 2'b01;
        #1;
        chk("t6_grant", 64'(rdy2), 64'(2'b01));
        @(posedge clk); #1;
        valid2 = 2'b00;
        chk("t6_busy_before", 64'(busy2), 64'(1'b1));
        #1 rst = 1'b1;
        #1;
        chk("t6_rv", 64'(rv2), 64'(2'b00));
        chk("t6_busy", 64'(busy2), 64'(1'b0));
        chk("t6_res", 64'(res2), 64'(0));
        chk("t6_ovf", 64'(ovf2), 64'(1'b0));
        chk("t6_sticky", 64'(sticky2), 64'(2'b00));
        @(posedge clk); #1;
        rst = 1'b0;
        last2 = 1;
        sticky_m = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6_no_stale", 64'(rv2), 64'(2'b00));
            chk("t6_idle", 64'(busy2), 64'(1'b0));
        end
        op2(2'b10, 0, 2'b00);
        op2(2'b11, 0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
